// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: main control FSM for the multicycle MIPS datapath.
// It sequences the shared memory, the IR, the register file and the ALU over
// 3-5 cycles per instruction.
// Optional feature macro: MULTICYCLE_CTRL_MEM_READY_EN. When it is defined,
// FETCH, MEMRD and MEMWR wait for mem_ready_i. When it is undefined,
// mem_ready_i is ignored.
module mips_multicycle_ctrl #(
    parameter logic [3:0] RESET_STATE = 4'd0,
    parameter int         OPC_W       = 6
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [OPC_W-1:0] opcode_i,
    input  logic             zero_i,
    input  logic             mem_ready_i,
    output logic             iord_o,
    output logic             mem_write_o,
    output logic             ir_write_o,
    output logic             reg_dst_o,
    output logic             mem_to_reg_o,
    output logic             reg_write_o,
    output logic             alu_src_a_o,
    output logic [1:0]       alu_src_b_o,
    output logic [1:0]       alu_op_o,
    output logic [1:0]       pc_src_o,
    output logic             pc_en_o,
    output logic [3:0]       state_o,
    output logic             illegal_o
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BEQ    = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    // Control word held in registers. pc_write and branch are internal terms;
    // they are combined with zero_i to form pc_en_o.
    typedef struct packed {
        logic       iord;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
        logic       pc_write;
        logic       branch;
    } ctrl_t;

    localparam logic [OPC_W-1:0] OP_R    = OPC_W'(6'b000000);
    localparam logic [OPC_W-1:0] OP_LW   = OPC_W'(6'b100011);
    localparam logic [OPC_W-1:0] OP_SW   = OPC_W'(6'b101011);
    localparam logic [OPC_W-1:0] OP_BEQ  = OPC_W'(6'b000100);
    localparam logic [OPC_W-1:0] OP_ADDI = OPC_W'(6'b001000);
    localparam logic [OPC_W-1:0] OP_J    = OPC_W'(6'b000010);

    state_t state_q, state_d;
    ctrl_t  ctrl_q;
    ctrl_t  ctrl_out;
    logic   mem_ok;
    logic   pc_gate;
    logic   opc_legal;

`ifdef MULTICYCLE_CTRL_MEM_READY_EN
    // Memory states advance only when memory accepts. In FETCH, the PC
    // update waits for the same handshake.
    assign mem_ok  = mem_ready_i;
    assign pc_gate = (state_q != S_FETCH) | mem_ready_i;
`else
    logic unused_mem_ready;
    assign unused_mem_ready = mem_ready_i;
    assign mem_ok  = 1'b1;
    assign pc_gate = 1'b1;
`endif

    assign opc_legal = (opcode_i == OP_R)   | (opcode_i == OP_LW)   |
                       (opcode_i == OP_SW)  | (opcode_i == OP_BEQ)  |
                       (opcode_i == OP_ADDI)| (opcode_i == OP_J);

    // Moore decode: this function gives the control word for one state.
    function automatic ctrl_t decode(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH:  begin c.ir_write = 1'b1; c.alu_src_b = 2'b01; c.pc_write = 1'b1; end
            S_DECODE: begin c.alu_src_b = 2'b11; end
            S_MEMADR: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
            S_MEMRD:  begin c.iord = 1'b1; end
            S_MEMWB:  begin c.mem_to_reg = 1'b1; c.reg_write = 1'b1; end
            S_MEMWR:  begin c.iord = 1'b1; c.mem_write = 1'b1; end
            S_EXEC:   begin c.alu_src_a = 1'b1; c.alu_op = 2'b10; end
            S_ALUWB:  begin c.reg_dst = 1'b1; c.reg_write = 1'b1; end
            S_BEQ:    begin c.alu_src_a = 1'b1; c.alu_op = 2'b01; c.pc_src = 2'b01; c.branch = 1'b1; end
            S_ADDIEX: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
            S_ADDIWB: begin c.reg_write = 1'b1; end
            S_JUMP:   begin c.pc_src = 2'b10; c.pc_write = 1'b1; end
            default:  c = '0;
        endcase
        return c;
    endfunction

    // Next-state selection. The opcode is used only in DECODE and MEMADR.
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = mem_ok ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if ((opcode_i == OP_LW) || (opcode_i == OP_SW)) state_d = S_MEMADR;
                else if (opcode_i == OP_R)    state_d = S_EXEC;
                else if (opcode_i == OP_BEQ)  state_d = S_BEQ;
                else if (opcode_i == OP_ADDI) state_d = S_ADDIEX;
                else if (opcode_i == OP_J)    state_d = S_JUMP;
                else                          state_d = S_FETCH;
            end
            S_MEMADR: state_d = (opcode_i == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  state_d = mem_ok ? S_MEMWB : S_MEMRD;
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWR:  state_d = mem_ok ? S_FETCH : S_MEMWR;
            S_EXEC:   state_d = S_ALUWB;
            S_ALUWB:  state_d = S_FETCH;
            S_BEQ:    state_d = S_FETCH;
            S_ADDIEX: state_d = S_ADDIWB;
            S_ADDIWB: state_d = S_FETCH;
            S_JUMP:   state_d = S_FETCH;
            default:  state_d = S_FETCH;
        endcase
    end

    // State register. The control word is registered from the next state, so
    // each output appears in the same cycle as the state it belongs to.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= state_t'(RESET_STATE);
            ctrl_q  <= decode(state_t'(RESET_STATE));
        end else begin
            state_q <= state_d;
            ctrl_q  <= decode(state_d);
        end
    end

    // While reset is high, every strobe is forced low. This also stops a
    // strobe at once when reset rises in the middle of an instruction.
    assign ctrl_out     = rst_i ? '0 : ctrl_q;

    assign iord_o       = ctrl_out.iord;
    assign mem_write_o  = ctrl_out.mem_write;
    assign ir_write_o   = ctrl_out.ir_write;
    assign reg_dst_o    = ctrl_out.reg_dst;
    assign mem_to_reg_o = ctrl_out.mem_to_reg;
    assign reg_write_o  = ctrl_out.reg_write;
    assign alu_src_a_o  = ctrl_out.alu_src_a;
    assign alu_src_b_o  = ctrl_out.alu_src_b;
    assign alu_op_o     = ctrl_out.alu_op;
    assign pc_src_o     = ctrl_out.pc_src;
    assign pc_en_o      = (ctrl_out.pc_write & pc_gate) | (ctrl_out.branch & zero_i);
    assign state_o      = state_q;
    assign illegal_o    = ~rst_i & (state_q == S_DECODE) & ~opc_legal;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl. Random instruction streams are compared with
// an instruction-level reference model. The model builds each opcode's
// expected state walk and looks up the control word for each state.
module tb_mips_multicycle_ctrl;

`ifdef MULTICYCLE_CTRL_MEM_READY_EN
  localparam bit MR_EN = 1'b1;
`else
  localparam bit MR_EN = 1'b0;
`endif

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic [5:0] opcode_i = '0;
  logic       zero_i = 1'b0;
  logic       mem_ready_i = 1'b1;
  logic       iord_o, mem_write_o, ir_write_o, reg_dst_o, mem_to_reg_o, reg_write_o;
  logic       alu_src_a_o, pc_en_o, illegal_o;
  logic [1:0] alu_src_b_o, alu_op_o, pc_src_o;
  logic [3:0] state_o;

  int n_checks = 0;
  int n_pass   = 0;

  mips_multicycle_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i), .opcode_i(opcode_i), .zero_i(zero_i),
    .mem_ready_i(mem_ready_i), .iord_o(iord_o), .mem_write_o(mem_write_o),
    .ir_write_o(ir_write_o), .reg_dst_o(reg_dst_o), .mem_to_reg_o(mem_to_reg_o),
    .reg_write_o(reg_write_o), .alu_src_a_o(alu_src_a_o), .alu_src_b_o(alu_src_b_o),
    .alu_op_o(alu_op_o), .pc_src_o(pc_src_o), .pc_en_o(pc_en_o),
    .state_o(state_o), .illegal_o(illegal_o)
  );

  // clock
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic bit is_legal(input logic [5:0] op);
    return op == 6'b000000 || op == 6'b100011 || op == 6'b101011 ||
           op == 6'b000100 || op == 6'b001000 || op == 6'b000010;
  endfunction

  // Observed control outputs packed in port order.
  function automatic logic [14:0] act_vec();
    return {iord_o, mem_write_o, ir_write_o, reg_dst_o, mem_to_reg_o, reg_write_o,
            alu_src_a_o, alu_src_b_o, alu_op_o, pc_src_o, pc_en_o, illegal_o};
  endfunction

  // Reference control word for each state, taken from the state table.
  function automatic logic [14:0] exp_vec(input int s, input logic [5:0] op,
                                          input logic z, input logic mr);
    logic iord, mw, irw, rd, m2r, rw, asa, pce, ill;
    logic [1:0] asb, aop, psrc;
    {iord, mw, irw, rd, m2r, rw, asa, pce, ill} = '0;
    {asb, aop, psrc} = '0;
    case (s)
      0:  begin irw = 1; asb = 2'd1; pce = MR_EN ? mr : 1'b1; end
      1:  begin asb = 2'd3; ill = !is_legal(op); end
      2:  begin asa = 1; asb = 2'd2; end
      3:  iord = 1;
      4:  begin m2r = 1; rw = 1; end
      5:  begin iord = 1; mw = 1; end
      6:  begin asa = 1; aop = 2'd2; end
      7:  begin rd = 1; rw = 1; end
      8:  begin asa = 1; aop = 2'd1; psrc = 2'd1; pce = z; end
      9:  begin asa = 1; asb = 2'd2; end
      10: rw = 1;
      11: begin psrc = 2'd2; pce = 1; end
      default: ;
    endcase
    return {iord, mw, irw, rd, m2r, rw, asa, asb, aop, psrc, pce, ill};
  endfunction

  // Expected state walk for one instruction.
  function automatic void build_seq(input logic [5:0] op, output int seq[$]);
    seq = {0, 1};
    case (op)
      6'b100011: seq = {0, 1, 2, 3, 4};
      6'b101011: seq = {0, 1, 2, 5};
      6'b000000: seq = {0, 1, 6, 7};
      6'b000100: seq = {0, 1, 8};
      6'b001000: seq = {0, 1, 9, 10};
      6'b000010: seq = {0, 1, 11};
      default:   seq = {0, 1};
    endcase
  endfunction

  // Driver task. Call it at a falling edge; it returns at a falling edge.
  // If abort_wr is set, reset is raised during the first MEMWR cycle.
  task automatic run_instr(input logic [5:0] op, input logic z, input bit abort_wr);
    int seq[$];
    int s;
    int budget;
    bit stall;
    logic mr;
    build_seq(op, seq);
    foreach (seq[k]) begin
      s = seq[k];
      budget = 0;
      stall = 1'b1;
      while (stall) begin
        mr = (budget > 6 || abort_wr) ? 1'b1 : 1'($urandom_range(0, 1));
        opcode_i = op; zero_i = z; mem_ready_i = mr;
        #1;
        check($sformatf("state op=%b k=%0d", op, k), 32'(state_o), 32'(s));
        check($sformatf("ctrl op=%b s=%0d z=%0b mr=%0b", op, s, z, mr),
              32'(act_vec()), 32'(exp_vec(s, op, z, mr)));
        if (abort_wr && s == 5) begin
          #1 rst_i = 1'b1;
          #1;
          check("abort state", 32'(state_o), 32'd0);
          check("abort ctrl", 32'(act_vec()), 32'd0);
          @(negedge clk_i);
          check("abort held ctrl", 32'(act_vec()), 32'd0);
          rst_i = 1'b0;
          return;
        end
        stall = MR_EN && (s == 0 || s == 3 || s == 5) && !mr;
        budget++;
        @(posedge clk_i);
        @(negedge clk_i);
      end
    end
  endtask

  initial begin
    logic [5:0] legal_ops[6];
    logic [5:0] op;
    legal_ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010};

    // Reset is held for two rising edges. All outputs must be low.
    rst_i = 1'b1;
    @(negedge clk_i);
    @(posedge clk_i);
    @(negedge clk_i);
    check("reset state", 32'(state_o), 32'd0);
    check("reset ctrl", 32'(act_vec()), 32'd0);
    rst_i = 1'b0;

    // Directed instructions: lw, R-type, sw, beq taken and not taken, j,
    // and one illegal opcode.
    run_instr(6'b100011, 1'b0, 1'b0);
    run_instr(6'b000000, 1'b0, 1'b0);
    run_instr(6'b101011, 1'b0, 1'b0);
    run_instr(6'b000100, 1'b1, 1'b0);
    run_instr(6'b000100, 1'b0, 1'b0);
    run_instr(6'b000010, 1'b1, 1'b0);
    run_instr(6'b111111, 1'b0, 1'b0);
    // Asynchronous reset during MEMWR, then a normal instruction afterwards.
    run_instr(6'b101011, 1'b0, 1'b1);
    run_instr(6'b001000, 1'b0, 1'b0);

    // Random instruction mix, with some illegal opcodes.
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 6) == 6) begin
        op = 6'b111111;
        for (int t = 0; t < 8; t++) begin
          op = 6'($urandom_range(0, 63));
          if (!is_legal(op)) break;
          op = 6'b111111;
        end
      end else begin
        op = legal_ops[$urandom_range(0, 5)];
      end
      run_instr(op, 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
